vga_timing_gen: RTL

- Parametrised successor to the team's fixed 640x480 VGA/LCD timing driver.
- Generates line/frame sync, display enable and a pixel-request stream with a programmable lead time (AHEAD cycles). Upstream frame buffers or ROM readers get AHEAD cycles of latency to return pixel data.
- Adds run/stop control with frame-boundary stop, configurable sync polarity, registered outputs, and line/frame start strobes.
- Sits between the pixel-clock PLL and the display connector, downstream of the frame buffer read logic.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Display-side and pixel-request signals of vga_timing_gen.
// master = timing generator, slave = frame-buffer reader / display.
interface vga_timing_gen_if #(
    parameter int DW = 24,
    parameter int CW = 12
);
    logic          run;
    logic [DW-1:0] pix_data;
    logic          tpg_sel;
    logic          lcd_dclk;
    logic          lcd_hs;
    logic          lcd_vs;
    logic          lcd_de;
    logic [DW-1:0] lcd_rgb;
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;
    logic          busy;

    modport master (
        input  run, pix_data, tpg_sel,
        output lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        output pix_req, pix_x, pix_y, line_start, frame_start, busy
    );

    modport slave (
        output run, pix_data, tpg_sel,
        input  lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        input  pix_req, pix_x, pix_y, line_start, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator with AHEAD-clock pixel requests and frame-boundary stop.
// Optional VGA_TPG_EN builds an 8-bar colour test pattern selected by tpg_sel.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int H_TOTAL = 800,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter int V_TOTAL = 525,
    parameter int AHEAD   = 1,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int DW      = 24,
    parameter int CW      = 12
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : g_bad_h
        $error("vga_timing_gen: horizontal terms do not sum to H_TOTAL");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : g_bad_v
        $error("vga_timing_gen: vertical terms do not sum to V_TOTAL");
    end
    if (AHEAD < 1 || AHEAD > H_SYNC + H_BACK) begin : g_bad_ahead
        $error("vga_timing_gen: AHEAD outside 1..H_SYNC+H_BACK");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_END   = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END   = CW'(V_SYNC);
    localparam logic [CW-1:0] H_DE_BEG = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_DE_END = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_DE_BEG = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_DE_END = CW'(V_SYNC + V_BACK + V_DISP);
    localparam logic [CW-1:0] H_RQ_BEG = CW'(H_SYNC + H_BACK - AHEAD);
    localparam logic [CW-1:0] H_RQ_END = CW'(H_SYNC + H_BACK + H_DISP - AHEAD);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic          h_wrap, v_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Stop is only honoured on the last clock of a frame, so frames are never truncated.
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        case (state)
            IDLE: begin
                if (bus.run) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                h_nxt = h_wrap ? '0 : h_cnt + CW'(1);
                v_nxt = v_cnt;
                if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + CW'(1);
                if (h_wrap && v_wrap && !bus.run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic act, hs_raw, vs_raw, v_win, de_raw, req_raw;

    assign act     = (state == ACTIVE);
    assign hs_raw  = act && (h_cnt < HS_END);
    assign vs_raw  = act && (v_cnt < VS_END);
    assign v_win   = (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
    assign de_raw  = act && v_win && (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
    assign req_raw = act && v_win && (h_cnt >= H_RQ_BEG) && (h_cnt < H_RQ_END);

    assign bus.pix_req = req_raw;
    assign bus.pix_x   = req_raw ? h_cnt - H_RQ_BEG : '0;
    assign bus.pix_y   = req_raw ? v_cnt - V_DE_BEG : '0;

    logic [DW-1:0] rgb_src;

`ifdef VGA_TPG_EN
    localparam int            FW      = DW / 3;
    localparam int            BAR_W   = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;
    localparam logic [CW-1:0] BAR_DIV = CW'(BAR_W);

    logic [CW-1:0] de_x, bar_q;
    logic [2:0]    bar;
    logic [DW-1:0] tpg_rgb;

    // Bar index to {R,G,B}: 0 white ... 7 black in standard colour-bar order.
    always_comb begin
        de_x    = h_cnt - H_DE_BEG;
        bar_q   = de_x / BAR_DIV;
        bar     = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];
        tpg_rgb = '0;
        tpg_rgb[3*FW-1 -: FW] = {FW{~bar[1]}};
        tpg_rgb[2*FW-1 -: FW] = {FW{~bar[2]}};
        tpg_rgb[FW-1   -: FW] = {FW{~bar[0]}};
    end

    assign rgb_src = bus.tpg_sel ? tpg_rgb : bus.pix_data;
`else
    logic unused_tpg_sel;

    assign unused_tpg_sel = bus.tpg_sel;
    assign rgb_src        = bus.pix_data;
`endif

    logic          hs_q, vs_q, de_q, ls_q, fs_q, busy_q;
    logic [DW-1:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            rgb_q  <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            hs_q   <= hs_raw ^ ~HS_POL;
            vs_q   <= vs_raw ^ ~VS_POL;
            de_q   <= de_raw;
            rgb_q  <= de_raw ? rgb_src : '0;
            ls_q   <= act && (h_cnt == '0);
            fs_q   <= act && (h_cnt == '0) && (v_cnt == '0);
            busy_q <= act;
        end
    end

    assign bus.lcd_dclk    = ~clk;
    assign bus.lcd_hs      = hs_q;
    assign bus.lcd_vs      = vs_q;
    assign bus.lcd_de      = de_q;
    assign bus.lcd_rgb     = rgb_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
endmodule
